// File: rtl/pcie_tx_mrd_req.sv
// pcie_tx_mrd_req: splits a host DMA read (up to 4 KB) into MRd TLP requests.
// Each chunk is bounded by MRRS and by the 4 KB address boundary. A tag and
// completion-FIFO space are allocated in the tag tracker before the TLP is
// handed to the TX engine.
//
// Handshakes:
//   mrd_req/mrd_req_ready : a request transfers on a clock edge where both are 1.
//   tx_mrd_req/ack        : tx_mrd_req rises and stays high with stable
//                           addr/len/tag until the edge where ack is 1; ack is
//                           never expected while tx_mrd_req is 0.
//   pcie_tag_alloc        : single-cycle strobe, no back-pressure; the tracker
//                           signals availability beforehand via pcie_tag_full_n.
module pcie_tx_mrd_req #(
  parameter int C_PCIE_ADDR_WIDTH  = 36,
  parameter int P_FIFO_DEPTH_WIDTH = 9
) (
  input  logic                              pcie_user_clk,
  input  logic                              pcie_user_rst_n,
  input  logic                              mrd_req,
  input  logic [C_PCIE_ADDR_WIDTH-1:6]      mrd_req_addr,
  input  logic [12:6]                       mrd_req_len,
  output logic                              mrd_req_ready,
  output logic                              mrd_done,
  input  logic [2:0]                        cfg_max_rd_req_size,
  output logic                              pcie_tag_alloc,
  output logic [7:0]                        pcie_alloc_tag,
  output logic [10:6]                       pcie_tag_alloc_len,
  input  logic                              pcie_tag_full_n,
  input  logic [P_FIFO_DEPTH_WIDTH:0]       rear_full_addr,
  input  logic [P_FIFO_DEPTH_WIDTH:0]       fifo_front_addr,
  output logic                              tx_mrd_req,
  input  logic                              tx_mrd_req_ack,
  output logic [C_PCIE_ADDR_WIDTH-1:6]      tx_mrd_addr,
  output logic [9:0]                        tx_mrd_len,
  output logic [7:0]                        tx_mrd_tag
);

  localparam int AW = C_PCIE_ADDR_WIDTH - 6;
  localparam int P  = P_FIFO_DEPTH_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_CHECK = 3'd2,
    S_ALLOC = 3'd3,
    S_ISSUE = 3'd4,
    S_NEXT  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [6:0]      remain_q, remain_d;
  logic [3:0]      chunk_q, chunk_d;
  logic [3:0]      tag_cnt_q, tag_cnt_d;
  logic [AW-1:0]   tx_addr_q, tx_addr_d;
  logic [9:0]      tx_len_q, tx_len_d;
  logic [7:0]      tx_tag_q, tx_tag_d;

  logic [3:0]      chunk_calc;
  logic [6:0]      bound_entries;
  logic [P:0]      fifo_used;
  logic [P+1:0]    fifo_free;
  logic            space_ok;
  logic            last_chunk;

  // Chunk size and FIFO space evaluation from the current registered state.
  always_comb begin
    bound_entries = 7'd64 - {1'b0, cur_addr_q[5:0]};
    case (cfg_max_rd_req_size)
      3'd0:    chunk_calc = 4'd2;
      3'd1:    chunk_calc = 4'd4;
      default: chunk_calc = 4'd8;
    endcase
    if (remain_q < {3'b000, chunk_calc})
      chunk_calc = remain_q[3:0];
    if (bound_entries < {3'b000, chunk_calc})
      chunk_calc = bound_entries[3:0];
    fifo_used  = rear_full_addr - fifo_front_addr;
    fifo_free  = {2'b01, {P{1'b0}}} - {1'b0, fifo_used};
    // A negative free count means inconsistent pointers; never allocate then.
    space_ok   = !fifo_free[P+1] && ({{(P-2){1'b0}}, chunk_q} <= fifo_free);
    last_chunk = (remain_q == {3'b000, chunk_q});
  end

  // State and datapath registers.
  always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
    if (!pcie_user_rst_n) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      chunk_q    <= '0;
      tag_cnt_q  <= '0;
      tx_addr_q  <= '0;
      tx_len_q   <= '0;
      tx_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      chunk_q    <= chunk_d;
      tag_cnt_q  <= tag_cnt_d;
      tx_addr_q  <= tx_addr_d;
      tx_len_q   <= tx_len_d;
      tx_tag_q   <= tx_tag_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mrd_req) state_d = S_CALC;
      S_CALC:  state_d = S_CHECK;
      S_CHECK: if (pcie_tag_full_n && space_ok) state_d = S_ALLOC;
      S_ALLOC: state_d = S_ISSUE;
      S_ISSUE: if (tx_mrd_req_ack) state_d = S_NEXT;
      S_NEXT:  state_d = last_chunk ? S_IDLE : S_CALC;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath register updates per state.
  always_comb begin
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    chunk_d    = chunk_q;
    tag_cnt_d  = tag_cnt_q;
    tx_addr_d  = tx_addr_q;
    tx_len_d   = tx_len_q;
    tx_tag_d   = tx_tag_q;
    case (state_q)
      S_IDLE: begin
        if (mrd_req) begin
          cur_addr_d = mrd_req_addr;
          // A length of 0 encodes a full 4 KB (64 entries).
          remain_d   = (mrd_req_len == 7'd0) ? 7'd64 : mrd_req_len;
        end
      end
      S_CALC:  chunk_d = chunk_calc;
      S_ALLOC: begin
        tx_addr_d = cur_addr_q;
        tx_len_d  = {2'b00, chunk_q, 4'b0000};
        tx_tag_d  = {4'b0001, tag_cnt_q};
        tag_cnt_d = tag_cnt_q + 4'd1;
      end
      S_NEXT: begin
        cur_addr_d = cur_addr_q + {{(AW-4){1'b0}}, chunk_q};
        remain_d   = remain_q - {3'b000, chunk_q};
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and registers.
  always_comb begin
    mrd_req_ready      = (state_q == S_IDLE);
    pcie_tag_alloc     = (state_q == S_ALLOC);
    pcie_alloc_tag     = {4'b0001, tag_cnt_q};
    pcie_tag_alloc_len = {1'b0, chunk_q};
    tx_mrd_req         = (state_q == S_ISSUE);
    tx_mrd_addr        = tx_addr_q;
    tx_mrd_len         = tx_len_q;
    tx_mrd_tag         = tx_tag_q;
    mrd_done           = (state_q == S_NEXT) && last_chunk;
  end

endmodule
